// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads words from imem over req/rdy,
// presents decoded fields to the control unit and applies redirects/halt.
//   state   | meaning
//   S_IDLE  | one dead cycle after reset release
//   S_FETCH | imem_req high, waiting for imem_rdy (bounded by WAIT_LIMIT)
//   S_HOLD  | instruction latched and valid, waiting for dec_ready
//   S_HALT  | terminal until reset (halt request, timeout or misaligned target)
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic            clk,
   input  logic            rst_b,
   output logic [31:0]     imem_addr,
   output logic            imem_req,
   input  logic            imem_rdy,
   input  logic [3:0][7:0] imem_data,
   input  logic            dec_ready,
   input  logic [31:0]     pc_branch,
   input  logic            pc_branch_en,
   input  logic [27:0]     pc_j,
   input  logic            pc_j_en,
   input  logic            halted,
   output logic [31:0]     inst_addr,
   output logic [5:0]      opcode,
   output logic [5:0]      func,
   output logic [4:0]      rs_num,
   output logic [4:0]      rt_num,
   output logic [4:0]      rd_num,
   output logic [4:0]      sh_amount,
   output logic [15:0]     imm,
   output logic [25:0]     address_j_format,
   output logic            inst_valid,
   output logic [31:0]     inst_count,
   output logic            fetch_err,
   output logic            halted_out
);

   localparam int unsigned WW = $clog2(WAIT_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [31:0]   r_pc;
   logic [31:0]   r_inst;
   logic [31:0]   r_inst_addr;
   logic [31:0]   r_count;
   logic [WW-1:0] r_wait;
   logic          r_err;

   logic [31:0]   w_seq_pc;
   logic [31:0]   w_jump_pc;
   logic [31:0]   w_branch_pc;
   logic [31:0]   w_next_pc;
   logic          w_misaligned;
   logic          w_timeout;
   logic          w_consume;

   assign w_seq_pc     = r_inst_addr + 32'd4;
   assign w_jump_pc    = {w_seq_pc[31:28], pc_j};
   assign w_branch_pc  = r_inst_addr + pc_branch;
   assign w_next_pc    = pc_j_en ? w_jump_pc : (pc_branch_en ? w_branch_pc : w_seq_pc);
   assign w_misaligned = |w_next_pc[1:0];
   assign w_timeout    = (r_wait == WAIT_LAST);
   assign w_consume    = (r_state == S_HOLD) && !halted && dec_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // halted outranks rdy/dec_ready in the same cycle
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = S_FETCH;
         S_FETCH: begin
            if (halted)         w_state_nx = S_HALT;
            else if (imem_rdy)  w_state_nx = S_HOLD;
            else if (w_timeout) w_state_nx = S_HALT;
         end
         S_HOLD: begin
            if (halted)         w_state_nx = S_HALT;
            else if (dec_ready) w_state_nx = w_misaligned ? S_HALT : S_FETCH;
         end
         S_HALT:  w_state_nx = S_HALT;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_pc        <= RESET_PC;
         r_inst      <= 32'd0;
         r_inst_addr <= RESET_PC;
         r_count     <= 32'd0;
         r_wait      <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state == S_FETCH && !halted) begin
            if (imem_rdy) begin
               r_inst      <= imem_data;
               r_inst_addr <= r_pc;
               r_wait      <= '0;
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end else begin
               r_wait <= r_wait + 1'b1;
            end
         end
         if (w_consume) begin
            r_count <= r_count + 32'd1;
            if (w_misaligned) r_err <= 1'b1;
            else              r_pc  <= w_next_pc;
         end
      end
   end

   assign imem_addr        = r_pc;
   assign imem_req         = (r_state == S_FETCH);
   assign inst_valid       = (r_state == S_HOLD);
   assign halted_out       = (r_state == S_HALT);
   assign fetch_err        = r_err;
   assign inst_count       = r_count;
   assign inst_addr        = r_inst_addr;
   assign opcode           = r_inst[31:26];
   assign rs_num           = r_inst[25:21];
   assign rt_num           = r_inst[20:16];
   assign rd_num           = r_inst[15:11];
   assign sh_amount        = r_inst[10:6];
   assign func             = r_inst[5:0];
   assign imm              = r_inst[15:0];
   assign address_j_format = r_inst[25:0];

endmodule
